// File: rtl/shifter_lfsr_multimode.sv
// -----------------------------------------------------------------------------
// shifter_lfsr_multimode
//
// General-purpose LFSR engine. It runs in Fibonacci or Galois form, and the
// form is selected at runtime. It takes a runtime list of tap indices, and
// slots may be left unused. It remembers the loaded seed so that it can detect
// wrap-around. It flags the all-zero lock-up state. It can optionally measure
// the sequence period.
//
// Optional feature macro: SHIFTER_LFSR_PERIOD_COUNT_EN
//   defined   : the step counter, o_period and o_period_valid are implemented
//   undefined : the counter is removed, and o_period / o_period_valid read 0
//
// Ports
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_enable       advance the LFSR one step this cycle
//   i_mode         0 = Fibonacci, 1 = Galois (left shift)
//   i_seed_load    load i_seed_data into the state and the seed register
//   i_seed_data    seed value
//   i_taps         TAP_COUNT tap indices; slot k is at [k*TAP_INDEX_WIDTH +: TAP_INDEX_WIDTH]
//                  value 1..WIDTH selects state bit value-1; 0 or >WIDTH is unused
//   o_lfsr_out     current state
//   o_lfsr_done    one-cycle pulse in the cycle the state returns to the seed
//   o_lockup       state is all zero (LOCKED)
//   o_period       steps measured for the last complete cycle
//   o_period_valid o_period holds a valid measurement
// -----------------------------------------------------------------------------
module shifter_lfsr_multimode #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned TAP_INDEX_WIDTH = 12,
    parameter int unsigned TAP_COUNT       = 4,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_enable,
    input  logic                                 i_mode,
    input  logic                                 i_seed_load,
    input  logic [WIDTH-1:0]                     i_seed_data,
    input  logic [TAP_COUNT*TAP_INDEX_WIDTH-1:0] i_taps,
    output logic [WIDTH-1:0]                     o_lfsr_out,
    output logic                                 o_lfsr_done,
    output logic                                 o_lockup,
    output logic [CNT_WIDTH-1:0]                 o_period,
    output logic                                 o_period_valid
);

    localparam int unsigned TIW  = TAP_INDEX_WIDTH;
    // The compare width leaves room for any WIDTH up to 64 as well as the full tap field.
    localparam int unsigned CMPW = TAP_INDEX_WIDTH + 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             done_q, done_d;
    logic             lockup_q, lockup_d;

`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cnt_inc_c;
`endif

    logic [WIDTH-1:0] fib_mask_c;
    logic [WIDTH-1:0] gal_mask_c;
    logic             fib_fb_c;
    logic [WIDTH-1:0] fib_next_c;
    logic [WIDTH-1:0] gal_next_c;
    logic [WIDTH-1:0] step_next_c;

    // Decode the tap slots into per-bit masks.
    // A mask bit toggles once for every slot that names it, so duplicate taps
    // cancel in pairs in both forms. Unused values (0 or >WIDTH) never match a bit.
    // The Galois mask covers bits 1..WIDTH-1 only, because tap WIDTH is implied there.
    always_comb begin
        fib_mask_c = '0;
        gal_mask_c = '0;
        for (int k = 0; k < int'(TAP_COUNT); k++) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
                if (CMPW'(i_taps[k*TIW +: TIW]) == CMPW'(j + 1)) begin
                    fib_mask_c[j] = ~fib_mask_c[j];
                end
                if ((j != 0) && (CMPW'(i_taps[k*TIW +: TIW]) == CMPW'(j))) begin
                    gal_mask_c[j] = ~gal_mask_c[j];
                end
            end
        end
    end

    // Fibonacci form: the XOR of the tapped bits is shifted in at bit 0.
    assign fib_fb_c   = ^(state_q & fib_mask_c);
    assign fib_next_c = {state_q[WIDTH-2:0], fib_fb_c};

    // Galois form: rotate left, and when the outgoing msb is set, XOR it into the tapped bits.
    assign gal_next_c = {state_q[WIDTH-2:0], state_q[WIDTH-1]}
                      ^ ({WIDTH{state_q[WIDTH-1]}} & gal_mask_c);

    assign step_next_c = i_mode ? gal_next_c : fib_next_c;

`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
    // Saturating increment of the step counter.
    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
`endif

    // Next-state logic and output logic.
    // Priority: seed_load wins over enable. Reset is handled in the register process.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        seed_d   = seed_q;
        done_d   = 1'b0;
        lockup_d = lockup_q;
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
`endif

        if (i_seed_load) begin
            state_d = i_seed_data;
            seed_d  = i_seed_data;
            fsm_d   = (i_seed_data == '0) ? ST_LOCKED : ST_RUN;
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
            cnt_d   = '0;
            valid_d = 1'b0;
`endif
        end else if (i_enable && (fsm_q != ST_LOCKED)) begin
            state_d = step_next_c;
            if (step_next_c == '0) begin
                // The taps have driven the state to zero, which is a lock-up.
                fsm_d = ST_LOCKED;
            end else if (fsm_q == ST_RUN) begin
                if (step_next_c == seed_q) begin
                    done_d   = 1'b1;
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
                    period_d = cnt_inc_c;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
`endif
                end else begin
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
                    cnt_d = cnt_inc_c;
`endif
                end
            end
        end

        lockup_d = (fsm_d == ST_LOCKED);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fsm_q    <= ST_IDLE;
            state_q  <= '1;
            seed_q   <= '1;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
`endif
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            seed_q   <= seed_d;
            done_q   <= done_d;
            lockup_q <= lockup_d;
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
`endif
        end
    end

    assign o_lfsr_out  = state_q;
    assign o_lfsr_done = done_q;
    assign o_lockup    = lockup_q;

`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
    assign o_period       = period_q;
    assign o_period_valid = valid_q;
`else
    assign o_period       = '0;
    assign o_period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_lfsr_multimode.sv
// -----------------------------------------------------------------------------
// Testbench for shifter_lfsr_multimode (WIDTH=8, four 12-bit tap slots).
// A reference model updates every clock, and the DUT outputs are checked
// against it after each edge. A table of hand-computed vectors is applied,
// followed by multi-cycle sequences and randomized stimulus.
// -----------------------------------------------------------------------------
module tb_shifter_lfsr_multimode;

    localparam int unsigned W   = 8;
    localparam int unsigned TIW = 12;
    localparam int unsigned TC  = 4;
    localparam int unsigned CW  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              mode;
    logic              seed_load;
    logic [W-1:0]      seed_data;
    logic [TC*TIW-1:0] taps;
    logic [W-1:0]      lfsr_out;
    logic              lfsr_done;
    logic              lockup;
    logic [CW-1:0]     period;
    logic              period_valid;

    int checks = 0;
    int errors = 0;

    shifter_lfsr_multimode #(
        .WIDTH(W), .TAP_INDEX_WIDTH(TIW), .TAP_COUNT(TC), .CNT_WIDTH(CW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_mode        (mode),
        .i_seed_load   (seed_load),
        .i_seed_data   (seed_data),
        .i_taps        (taps),
        .o_lfsr_out    (lfsr_out),
        .o_lfsr_done   (lfsr_done),
        .o_lockup      (lockup),
        .o_period      (period),
        .o_period_valid(period_valid)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [W-1:0]  m_state;
    logic [W-1:0]  m_seed;
    bit            m_armed;
    bit            m_locked;
    bit            m_done;
    longint        m_cnt;
    longint        m_period;
    bit            m_valid;

    function automatic logic [TC*TIW-1:0] mk_taps(input int a, input int b, input int c, input int d);
        return {TIW'(d), TIW'(c), TIW'(b), TIW'(a)};
    endfunction

    // One LFSR step, computed from the tap list.
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic md,
                                              input logic [TC*TIW-1:0] tp);
        int           t;
        bit           fb;
        logic [W-1:0] poly;
        logic [W-1:0] sh;
        fb   = 1'b0;
        poly = '0;
        for (int k = 0; k < int'(TC); k++) begin
            t = int'(tp[k*TIW +: TIW]);
            if (t >= 1 && t <= int'(W)) fb = fb ^ s[t-1];
            if (t >= 1 && t < int'(W))  poly[t] = ~poly[t];
        end
        sh = s << 1;
        if (!md) return sh | W'(fb);
        return s[W-1] ? ((sh | W'(1)) ^ poly) : sh;
    endfunction

    task automatic model_update(input logic r, input logic l, input logic e, input logic md,
                                input logic [W-1:0] sd, input logic [TC*TIW-1:0] tp);
        logic [W-1:0] nxt;
        longint       cmax;
        cmax   = (longint'(1) << CW) - 1;
        m_done = 1'b0;
        if (!r) begin
            m_state = '1; m_seed = '1; m_armed = 0; m_locked = 0;
            m_cnt = 0; m_period = 0; m_valid = 0;
        end else if (l) begin
            m_state  = sd;
            m_seed   = sd;
            m_cnt    = 0;
            m_valid  = 0;
            m_locked = (sd == '0);
            m_armed  = (sd != '0);
        end else if (e && !m_locked) begin
            nxt     = ref_step(m_state, md, tp);
            m_state = nxt;
            if (nxt == '0) begin
                m_locked = 1;
                m_armed  = 0;
            end else if (m_armed) begin
                if (nxt == m_seed) begin
                    m_done   = 1'b1;
                    m_period = (m_cnt + 1 > cmax) ? cmax : m_cnt + 1;
                    m_valid  = 1'b1;
                    m_cnt    = 0;
                end else begin
                    m_cnt = (m_cnt + 1 > cmax) ? cmax : m_cnt + 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, and compare every output to it.
    task automatic cyc(input logic r, input logic l, input logic e, input logic md,
                       input logic [W-1:0] sd, input logic [TC*TIW-1:0] tp);
        logic [CW-1:0] exp_p;
        logic          exp_v;
        rst_n = r; seed_load = l; enable = e; mode = md; seed_data = sd; taps = tp;
        @(posedge clk);
        model_update(r, l, e, md, sd, tp);
        #1;
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
        exp_p = CW'(m_period);
        exp_v = m_valid;
`else
        exp_p = '0;
        exp_v = 1'b0;
`endif
        chk("model_out",    64'(lfsr_out),     64'(m_state));
        chk("model_done",   64'(lfsr_done),    64'(m_done));
        chk("model_lockup", 64'(lockup),       64'(m_locked));
        chk("model_period", 64'(period),       64'(exp_p));
        chk("model_valid",  64'(period_valid), 64'(exp_v));
    endtask

    typedef struct {
        logic          rst_n;
        logic          load;
        logic          en;
        logic          md;
        logic [W-1:0]  seed;
        logic [TC*TIW-1:0] tp;
        logic [W-1:0]  exp_out;
        logic          exp_lock;
        logic          exp_done;
    } vec_t;

    function automatic vec_t mk_vec(input logic r, input logic l, input logic e, input logic md,
                                    input logic [W-1:0] sd, input logic [TC*TIW-1:0] tp,
                                    input logic [W-1:0] eo, input logic elk, input logic ed);
        vec_t v;
        v.rst_n = r; v.load = l; v.en = e; v.md = md; v.seed = sd; v.tp = tp;
        v.exp_out = eo; v.exp_lock = elk; v.exp_done = ed;
        return v;
    endfunction

    initial begin
        vec_t              vecs[14];
        logic [TC*TIW-1:0] t_a;
        logic [TC*TIW-1:0] t_ref;
        logic [W-1:0]      exp_s;
        int                pulses;
        int                first_i;
        int                second_i;
        logic              md_r;
        logic [TC*TIW-1:0] tp_r;

        rst_n = 1'b0; seed_load = 1'b0; enable = 1'b0; mode = 1'b0;
        seed_data = '0; taps = '0;
        m_state = '1; m_seed = '1; m_armed = 0; m_locked = 0; m_done = 0;
        m_cnt = 0; m_period = 0; m_valid = 0;

        t_a = mk_taps(8, 6, 5, 4);

        // Hand-computed vectors: {rst_n, load, en, mode, seed, taps} -> {out, lockup, done}
        vecs[0]  = mk_vec(0, 0, 0, 0, 8'h00, t_a, 8'hFF, 0, 0);
        vecs[1]  = mk_vec(1, 1, 0, 0, 8'h01, t_a, 8'h01, 0, 0);
        vecs[2]  = mk_vec(1, 0, 1, 0, 8'h00, t_a, 8'h02, 0, 0);
        vecs[3]  = mk_vec(1, 0, 1, 0, 8'h00, t_a, 8'h04, 0, 0);
        vecs[4]  = mk_vec(1, 1, 0, 1, 8'h80, t_a, 8'h80, 0, 0);
        vecs[5]  = mk_vec(1, 0, 1, 1, 8'h00, t_a, 8'h71, 0, 0);
        vecs[6]  = mk_vec(1, 0, 1, 1, 8'h00, t_a, 8'hE2, 0, 0);
        vecs[7]  = mk_vec(1, 0, 1, 1, 8'h00, t_a, 8'hB5, 0, 0);
        vecs[8]  = mk_vec(1, 1, 1, 0, 8'h00, t_a, 8'h00, 1, 0);
        vecs[9]  = mk_vec(1, 0, 1, 0, 8'h00, t_a, 8'h00, 1, 0);
        vecs[10] = mk_vec(1, 1, 0, 0, 8'h5A, t_a, 8'h5A, 0, 0);
        vecs[11] = mk_vec(1, 1, 1, 0, 8'h3C, t_a, 8'h3C, 0, 0);
        vecs[12] = mk_vec(1, 0, 1, 0, 8'h00, t_a, 8'h79, 0, 0);
        vecs[13] = mk_vec(0, 0, 1, 0, 8'h00, t_a, 8'hFF, 0, 0);

        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].rst_n, vecs[i].load, vecs[i].en, vecs[i].md, vecs[i].seed, vecs[i].tp);
            chk($sformatf("vec%0d_out", i),  64'(lfsr_out),  64'(vecs[i].exp_out));
            chk($sformatf("vec%0d_lock", i), 64'(lockup),    64'(vecs[i].exp_lock));
            chk($sformatf("vec%0d_done", i), 64'(lfsr_done), 64'(vecs[i].exp_done));
        end

        // Fibonacci, seed 0x01: done pulses after 255 and 510 steps.
        cyc(1, 1, 0, 0, 8'h01, t_a);
        pulses = 0; first_i = -1; second_i = -1;
        for (int i = 1; i <= 510; i++) begin
            cyc(1, 0, 1, 0, 8'h00, t_a);
            if (lfsr_done) begin
                pulses++;
                if (first_i < 0) first_i = i;
                else if (second_i < 0) second_i = i;
            end
            if (i == 255) begin
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
                chk("fib_period", 64'(period), 64'd255);
                chk("fib_valid",  64'(period_valid), 64'd1);
`else
                chk("fib_period_off", 64'(period), 64'd0);
                chk("fib_valid_off",  64'(period_valid), 64'd0);
`endif
            end
        end
        chk("fib_pulses", 64'(pulses), 64'd2);
        chk("fib_first",  64'(first_i), 64'd255);
        chk("fib_second", 64'(second_i), 64'd510);

        // Galois, seed 0x80: the first step is 0x71 and the wrap comes after 255 steps.
        cyc(1, 1, 0, 1, 8'h80, t_a);
        pulses = 0; first_i = -1;
        for (int i = 1; i <= 255; i++) begin
            cyc(1, 0, 1, 1, 8'h00, t_a);
            if (i == 1) chk("gal_first_step", 64'(lfsr_out), 64'h71);
            if (lfsr_done) begin
                pulses++;
                if (first_i < 0) first_i = i;
            end
        end
        chk("gal_pulses", 64'(pulses), 64'd1);
        chk("gal_wrap_at", 64'(first_i), 64'd255);
`ifdef SHIFTER_LFSR_PERIOD_COUNT_EN
        chk("gal_period", 64'(period), 64'd255);
`endif

        // Lock-up: seed 0 holds for 20 cycles with no done pulse, and a reload recovers.
        cyc(1, 1, 1, 0, 8'h00, t_a);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1, 0, 8'h00, t_a);
            if (lfsr_done) pulses++;
        end
        chk("lock_state", 64'(lfsr_out), 64'h00);
        chk("lock_flag",  64'(lockup), 64'd1);
        chk("lock_nodone", 64'(pulses), 64'd0);
        cyc(1, 1, 0, 0, 8'h5A, t_a);
        chk("unlock_flag", 64'(lockup), 64'd0);
        cyc(1, 0, 1, 0, 8'h00, t_a);
        chk("unlock_step", 64'(lfsr_out), 64'(ref_step(8'h5A, 1'b0, t_a)));

        // The load wins over enable, and a reset mid-sequence clears everything.
        cyc(1, 1, 1, 0, 8'h3C, t_a);
        chk("load_wins", 64'(lfsr_out), 64'h3C);
        for (int i = 0; i < 300; i++) cyc(1, 0, 1, 0, 8'h00, t_a);
        cyc(0, 0, 1, 0, 8'h00, t_a);
        chk("rst_out",   64'(lfsr_out), 64'hFF);
        chk("rst_valid", 64'(period_valid), 64'd0);
        chk("rst_lock",  64'(lockup), 64'd0);

        // Unused slots (0, 15) and a cancelling duplicate both match the two-tap sequence.
        t_ref = mk_taps(8, 6, 0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            tp_r = (pass == 0) ? mk_taps(8, 6, 0, 15) : mk_taps(8, 6, 5, 5);
            cyc(1, 1, 0, 0, 8'h01, tp_r);
            exp_s = 8'h01;
            for (int i = 0; i < 40; i++) begin
                exp_s = ref_step(exp_s, 1'b0, t_ref);
                cyc(1, 0, 1, 0, 8'h00, tp_r);
                chk($sformatf("two_tap_p%0d_s%0d", pass, i), 64'(lfsr_out), 64'(exp_s));
            end
        end

        // Randomized stimulus checked against the model.
        md_r = 1'b0;
        tp_r = t_a;
        cyc(1, 1, 0, 0, 8'hA5, tp_r);
        for (int i = 0; i < 3000; i++) begin
            logic r, l, e;
            logic [W-1:0] sd;
            r  = ($urandom_range(0, 199) != 0);
            l  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 9) < 8);
            sd = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            if ($urandom_range(0, 99) == 0) md_r = ~md_r;
            if ($urandom_range(0, 149) == 0) begin
                tp_r = mk_taps(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            cyc(r, l, e, md_r, sd, tp_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_lfsr_multimode.md
Name: shifter_lfsr_multimode

Overview:
Parameterised LFSR engine that can run in Fibonacci or Galois form, selected at runtime. It takes a variable number of taps, with unused tap slots allowed. It tracks the latched seed to detect wrap-around, flags the all-zero lock-up state and can report the measured sequence period. It is the general-purpose pseudo-random and pattern source for BIST, scramblers and testbench stimulus blocks in the common library.

Parameters:
- WIDTH, 8, LFSR state width; legal range 3..64.
- TAP_INDEX_WIDTH, 12, bits per tap index field.
- TAP_COUNT, 4, number of tap slots in i_taps; range 1..8.
- CNT_WIDTH, 32, width of the period counter; saturates at all-ones.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset. Synchronous, active-low.
- i_enable  input  1  advance the LFSR one step per cycle.
- i_mode  input  1  0 = Fibonacci, 1 = Galois.
- i_seed_load  input  1  load the seed into the state and the seed register.
- i_seed_data  input  WIDTH  seed value.
- i_taps  input  TAP_COUNT*TAP_INDEX_WIDTH  concatenated tap indices; slot k occupies bits [k*TIW +: TIW].
- o_lfsr_out  output  WIDTH  current state.
- o_lfsr_done  output  1  one-cycle pulse when the state returns to the seed.
- o_lockup  output  1  state is all zero.
- o_period  output  CNT_WIDTH  steps measured for the last complete cycle.
- o_period_valid  output  1  o_period holds a valid measurement.

Behaviour:
- Tap encoding:
  - Value t in 1..WIDTH selects state bit t-1.
  - Value 0, or any value greater than WIDTH, means the slot is unused and contributes nothing.
  - Duplicate tap values cancel in pairs, as XOR semantics dictate; no error is raised.
- Fibonacci step:
  - fb = XOR of state[t-1] over all valid taps.
  - next = {state[WIDTH-2:0], fb}.
- Galois step (left shift):
  - msb = state[WIDTH-1].
  - next[0] = msb.
  - For i = 1..WIDTH-1: next[i] = state[i-1] ^ (msb & m[i]), where m[i] = 1 if any valid tap equals i.
  - Tap value WIDTH is implied in Galois mode and ignored if present.
- Priority each clock edge: reset > seed_load > enable > hold.
- Reset (i_rst_n = 0 at an edge, including mid-sequence):
  - state = all ones; seed register = all ones.
  - o_lfsr_done = 0, o_lockup = 0, o_period = 0, o_period_valid = 0.
  - Step counter = 0; FSM goes to IDLE.
- FSM states: IDLE, RUN, LOCKED.
  - IDLE: no sequence armed. seed_load moves to RUN, or to LOCKED if the seed is 0. Enable steps the state but does not count.
  - RUN:
    - Each enabled step increments the step counter, saturating.
    - If next == seed register: pulse o_lfsr_done the following cycle, capture counter+1 into o_period, set o_period_valid, reset the counter to 0 and stay in RUN.
  - LOCKED: entered when the state is all zero. o_lockup = 1, the state holds at 0 and enable has no effect. Leave only via seed_load with a non-zero seed, or via reset.
- seed_load:
  - state <= i_seed_data and seed register <= i_seed_data.
  - Counter cleared; o_period_valid cleared; o_lfsr_done forced 0 in the next cycle.
  - seed_load together with enable: the load wins and no step occurs.
- A change of i_mode or i_taps while in RUN takes effect on the next step. The counter is not cleared automatically; software reloads the seed to re-measure.
- Latency: o_lfsr_out and o_lockup update in the cycle after the enabling edge. o_lfsr_done, o_period and o_period_valid update on the same edge as the wrapping step.
- Counter saturation at 2^CNT_WIDTH-1: o_period_valid stays 0 until a wrap occurs.

Optional Feature:
- Macro: SHIFTER_LFSR_PERIOD_COUNT_EN.
- Defined: step counter, o_period and o_period_valid are implemented as described above.
- Undefined: counter logic is removed; o_period is tied to 0 and o_period_valid to 0. Done and lock-up behaviour are unchanged.

Test Plan:
- WIDTH=8, taps {8,6,5,4}, Fibonacci, seed 0x01, enable:
  - First output is 0x02.
  - After 255 steps, o_lfsr_done pulses once and o_period = 255 with o_period_valid = 1.
  - A second pulse follows 255 steps later.
- Same taps, Galois mode, seed 0x80, one step:
  - o_lfsr_out = 0x71.
  - Wrap after 255 steps with o_period = 255.
- Load seed 0x00 and enable:
  - o_lockup = 1 and the state holds at 0x00 for 20 cycles with no done pulse.
  - Reload seed 0x5A: o_lockup = 0 and stepping resumes.
- seed_load=1 with enable=1 and seed 0x3C:
  - Next o_lfsr_out = 0x3C, with no step applied.
  - Assert reset after 100 steps: next cycle o_lfsr_out = 0xFF and o_period_valid = 0.
- Taps {8,6,0,15} with WIDTH=8:
  - Slots 0 and 15 are ignored; sequence matches the two-tap reference model.
  - Taps {8,6,5,5} give a sequence identical to {8,6}.
- Build without SHIFTER_LFSR_PERIOD_COUNT_EN, run the first scenario:
  - Done pulses still every 255 steps.
  - o_period and o_period_valid remain 0 throughout.
